// File: rtl/seg_display_arbiter.sv
// Display owner arbitration between the clock and four services, plus the
// anode scan, BCD-to-7-segment decode and edit-digit blink for the shared display.
module seg_display_arbiter #(
    parameter int SCAN_DIV  = 65536,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk_osc,
    input  logic        resetn,
    input  logic [3:0]  svc_sel,
    input  logic [3:0]  finish,
    input  logic [15:0] num_time,
    input  logic [15:0] num_s1,
    input  logic [15:0] num_s2,
    input  logic [15:0] num_s3,
    input  logic [15:0] num_s4,
    input  logic [3:0]  edit_sel,
    output logic [3:0]  anode,
    output logic [7:0]  seg,
    output logic [2:0]  owner,
    output logic [3:0]  svc_led
);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    typedef enum logic [2:0] {IDLE = 3'd0, OWN1 = 3'd1, OWN2 = 3'd2, OWN3 = 3'd3, OWN4 = 3'd4} state_t;

    state_t          state;
    logic [3:0]      s_meta, ss, done, done_base, own_code;
    logic [SW-1:0]   scan_cnt;
    logic [BW-1:0]   blink_cnt;
    logic [1:0]      idx;
    logic            phase;
    logic [15:0]     cur;
    logic [3:0]      digit;
    logic            blank;

    always_ff @(posedge clk_osc or negedge resetn) begin
        if (!resetn) begin
            s_meta <= '0;
            ss     <= '0;
        end else begin
            s_meta <= svc_sel;
            ss     <= s_meta;
        end
    end

    // own_code is the owner's switch code in svc_sel bit order; doubles as the LED.
    always_comb begin
        case (state)
            OWN1:    own_code = 4'b1000;
            OWN2:    own_code = 4'b0100;
            OWN3:    own_code = 4'b0010;
            OWN4:    own_code = 4'b0001;
            default: own_code = 4'b0000;
        endcase
    end

    assign svc_led   = own_code;
    assign owner     = state;
    assign done_base = (ss == 4'b0000) ? 4'b0000 : done;

    always_ff @(posedge clk_osc or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            done  <= '0;
        end else begin
            done <= done_base;
            case (state)
                IDLE: begin
                    if ((ss & done) == 4'b0000) begin
                        case (ss)
                            4'b1000: state <= OWN1;
                            4'b0100: state <= OWN2;
                            4'b0010: state <= OWN3;
                            4'b0001: state <= OWN4;
                            default: state <= IDLE;
                        endcase
                    end
                end
                default: begin
                    if ((finish & own_code) != 4'b0000) begin
                        state <= IDLE;
                        done  <= done_base | own_code;
                    end else if (ss != own_code) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Scan and blink timers free-run; ownership changes never restart them.
    always_ff @(posedge clk_osc or negedge resetn) begin
        if (!resetn) begin
            scan_cnt  <= '0;
            idx       <= 2'd0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        case (state)
            OWN1:    cur = num_s1;
            OWN2:    cur = num_s2;
            OWN3:    cur = num_s3;
            OWN4:    cur = num_s4;
            default: cur = num_time;
        endcase
        case (idx)
            2'd0:    digit = cur[3:0];
            2'd1:    digit = cur[7:4];
            2'd2:    digit = cur[11:8];
            default: digit = cur[15:12];
        endcase
        // Only the set-time / set-alarm services edit digits.
        blank = ((state == OWN1) || (state == OWN2)) && edit_sel[idx] && phase;
    end

    function automatic logic [7:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 8'hC0;
            4'd1:    decode = 8'hF9;
            4'd2:    decode = 8'hA4;
            4'd3:    decode = 8'hB0;
            4'd4:    decode = 8'h99;
            4'd5:    decode = 8'h92;
            4'd6:    decode = 8'h82;
            4'd7:    decode = 8'hF8;
            4'd8:    decode = 8'h80;
            4'd9:    decode = 8'h90;
            default: decode = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk_osc or negedge resetn) begin
        if (!resetn) begin
            anode <= 4'hF;
            seg   <= 8'hFF;
        end else begin
            anode <= blank ? 4'hF : ~(4'b0001 << idx);
            seg   <= decode(digit) & ((idx == 2'd2) ? 8'h7F : 8'hFF);
        end
    end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench: expected pin values are queued as stimulus is applied and
// compared after each edge; ownership timing is checked inline per scenario.
module tb_seg_display_arbiter;
    localparam int SD = 4;
    localparam int BD = 16;

    logic        clk_osc = 1'b0;
    logic        resetn  = 1'b0;
    logic [3:0]  svc_sel = 4'b0, finish = 4'b0, edit_sel = 4'b0;
    logic [15:0] num_time = 16'h1234, num_s1 = 16'h5678, num_s2 = 16'h0905;
    logic [15:0] num_s3 = 16'h3456, num_s4 = 16'h7890;
    logic [3:0]  anode, svc_led;
    logic [7:0]  seg;
    logic [2:0]  owner;

    int vectors = 0, errors = 0, cyc = 0;
    logic [11:0] expq[$];
    logic [11:0] got, want;

    seg_display_arbiter #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk_osc(clk_osc), .resetn(resetn), .svc_sel(svc_sel), .finish(finish),
        .num_time(num_time), .num_s1(num_s1), .num_s2(num_s2), .num_s3(num_s3),
        .num_s4(num_s4), .edit_sel(edit_sel), .anode(anode), .seg(seg),
        .owner(owner), .svc_led(svc_led)
    );

    always #5 clk_osc = ~clk_osc;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0; 4'd1: return 8'hF9; 4'd2: return 8'hA4; 4'd3: return 8'hB0;
            4'd4: return 8'h99; 4'd5: return 8'h92; 4'd6: return 8'h82; 4'd7: return 8'hF8;
            4'd8: return 8'h80; 4'd9: return 8'h90; default: return 8'hFF;
        endcase
    endfunction

    // Expected {anode,seg} just after edge n (counted from reset release),
    // given the owner and data seen before that edge.
    function automatic logic [11:0] pins(input int own, input logic [15:0] data,
                                         input logic [3:0] edit, input int n);
        int slot, ph;
        logic [15:0] tmp;
        logic [3:0]  an;
        logic [7:0]  sg;
        slot = ((n - 1) / SD) % 4;
        ph   = ((n - 1) / BD) % 2;
        tmp  = data >> (slot * 4);
        sg   = seg_of(tmp[3:0]);
        if (slot == 2) sg[7] = 1'b0;
        an = 4'hF;
        an[slot] = 1'b0;
        if ((own == 1 || own == 2) && edit[slot] && ph == 1) an = 4'hF;
        return {an, sg};
    endfunction

    task automatic tick();
        @(posedge clk_osc);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        svc_sel = 4'b0; num_time = 16'h1234;
        repeat (2) @(posedge clk_osc);
        #1;
        vectors++;
        if ({anode, seg, owner, svc_led} !== {4'hF, 8'hFF, 3'd0, 4'b0}) begin
            errors++;
            $display("FAIL reset_values got an=%b seg=%h own=%0d led=%b want an=1111 seg=ff own=0 led=0000",
                     anode, seg, owner, svc_led);
        end
        resetn = 1'b1; cyc = 0;
        for (int i = 0; i < 16; i++) begin
            expq.push_back(pins(0, num_time, edit_sel, cyc + 1));
            tick();
            got = {anode, seg}; want = expq.pop_front(); vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_scan cyc=%0d got=%h want=%h", cyc, got, want);
            end
        end
        vectors++;
        if (owner !== 3'd0) begin
            errors++;
            $display("FAIL idle_owner got=%0d want=0", owner);
        end
    endtask

    task automatic test_grant();
        num_s2 = 16'h0905; svc_sel = 4'b0100;
        for (int j = 1; j <= 3; j++) begin
            expq.push_back(pins(0, num_time, edit_sel, cyc + 1));
            tick();
            got = {anode, seg}; want = expq.pop_front(); vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL grant_pins cyc=%0d got=%h want=%h", cyc, got, want);
            end
            vectors++;
            if (owner !== ((j == 3) ? 3'd2 : 3'd0) || svc_led !== ((j == 3) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL grant_latency edge=%0d got own=%0d led=%b", j, owner, svc_led);
            end
        end
        for (int i = 0; i < 16; i++) begin
            expq.push_back(pins(2, num_s2, edit_sel, cyc + 1));
            tick();
            got = {anode, seg}; want = expq.pop_front(); vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL own2_scan cyc=%0d got=%h want=%h", cyc, got, want);
            end
        end
    endtask

    task automatic test_blink();
        edit_sel = 4'b0001;
        for (int i = 0; i < 40; i++) begin
            expq.push_back(pins(2, num_s2, edit_sel, cyc + 1));
            tick();
            got = {anode, seg}; want = expq.pop_front(); vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL blink cyc=%0d got=%h want=%h", cyc, got, want);
            end
        end
        edit_sel = 4'b0;
    endtask

    task automatic test_finish();
        svc_sel = 4'b0;
        repeat (4) tick();
        svc_sel = 4'b1000;
        repeat (3) tick();
        vectors++;
        if (owner !== 3'd1 || svc_led !== 4'b1000) begin
            errors++;
            $display("FAIL own1_grant got own=%0d led=%b want 1/1000", owner, svc_led);
        end
        expq.push_back(pins(1, num_s1, edit_sel, cyc + 1));
        finish = 4'b1000;
        tick();
        finish = 4'b0;
        got = {anode, seg}; want = expq.pop_front(); vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL finish_pins0 got=%h want=%h", got, want);
        end
        vectors++;
        if (owner !== 3'd0) begin
            errors++;
            $display("FAIL finish_release got=%0d want=0", owner);
        end
        expq.push_back(pins(0, num_time, edit_sel, cyc + 1));
        tick();
        got = {anode, seg}; want = expq.pop_front(); vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL finish_pins1 got=%h want=%h", got, want);
        end
        repeat (5) tick();
        vectors++;
        if (owner !== 3'd0) begin
            errors++;
            $display("FAIL done_hold got=%0d want=0", owner);
        end
        svc_sel = 4'b0;
        repeat (3) tick();
        svc_sel = 4'b1000;
        repeat (2) tick();
        vectors++;
        if (owner !== 3'd0) begin
            errors++;
            $display("FAIL regrant_early got=%0d want=0", owner);
        end
        tick();
        vectors++;
        if (owner !== 3'd1) begin
            errors++;
            $display("FAIL regrant got=%0d want=1", owner);
        end
    endtask

    task automatic test_multi_hot();
        svc_sel = 4'b0;
        repeat (4) tick();
        svc_sel = 4'b0010;
        repeat (3) tick();
        vectors++;
        if (owner !== 3'd3) begin
            errors++;
            $display("FAIL own3_grant got=%0d want=3", owner);
        end
        svc_sel = 4'b0011;
        repeat (2) tick();
        vectors++;
        if (owner !== 3'd3) begin
            errors++;
            $display("FAIL multi_early got=%0d want=3", owner);
        end
        tick();
        vectors++;
        if (owner !== 3'd0) begin
            errors++;
            $display("FAIL multi_release got=%0d want=0", owner);
        end
        repeat (4) tick();
        vectors++;
        if (owner !== 3'd0) begin
            errors++;
            $display("FAIL multi_idle got=%0d want=0", owner);
        end
        svc_sel = 4'b0001;
        repeat (3) tick();
        vectors++;
        if (owner !== 3'd4 || svc_led !== 4'b0001) begin
            errors++;
            $display("FAIL own4_grant got own=%0d led=%b want 4/0001", owner, svc_led);
        end
    endtask

    task automatic test_blank();
        svc_sel = 4'b0;
        repeat (4) tick();
        svc_sel = 4'b0010;
        repeat (3) tick();
        vectors++;
        if (owner !== 3'd3) begin
            errors++;
            $display("FAIL own3_regrant got=%0d want=3", owner);
        end
        num_s3 = 16'hA1F0; edit_sel = 4'b1111;
        for (int i = 0; i < 32; i++) begin
            expq.push_back(pins(3, num_s3, edit_sel, cyc + 1));
            tick();
            got = {anode, seg}; want = expq.pop_front(); vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL blank_scan cyc=%0d got=%h want=%h", cyc, got, want);
            end
        end
        edit_sel = 4'b0;
    endtask

    task automatic test_async_reset();
        svc_sel = 4'b0;
        repeat (4) tick();
        svc_sel = 4'b1000;
        repeat (3) tick();
        finish = 4'b1000;
        tick();
        finish = 4'b0;
        repeat (3) tick();
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if ({anode, seg, owner, svc_led} !== {4'hF, 8'hFF, 3'd0, 4'b0}) begin
            errors++;
            $display("FAIL async_reset got an=%b seg=%h own=%0d led=%b", anode, seg, owner, svc_led);
        end
        @(posedge clk_osc);
        #1 resetn = 1'b1; cyc = 0;
        for (int j = 1; j <= 3; j++) begin
            expq.push_back(pins(0, num_time, edit_sel, cyc + 1));
            tick();
            got = {anode, seg}; want = expq.pop_front(); vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL rerelease_pins cyc=%0d got=%h want=%h", cyc, got, want);
            end
        end
        vectors++;
        if (owner !== 3'd1) begin
            errors++;
            $display("FAIL done_cleared_by_reset got=%0d want=1", owner);
        end
    endtask

    initial begin
        test_reset();
        test_grant();
        test_blink();
        test_finish();
        test_multi_hot();
        test_blank();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
